// File: rtl/pwm_dac_multi.sv
// pwm_dac_multi
// Multi-channel PWM DAC driven by one shared phase counter. Each channel's
// duty word is staged in a shadow register and copied into the active
// register only at a period boundary, so a duty change never cuts a pulse
// short. Edge-aligned or centre-aligned counting is selected per period,
// and a prescaler slows the counter to one step every DIV clocks.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           run enable; low holds the counter and outputs at zero
//   mode         0 = edge-aligned, 1 = centre-aligned (applied at boundaries)
//   load         1-cycle strobe capturing duty_in into the shadow registers
//   duty_in      channel i duty at bits [i*WIDTH +: WIDTH]
//   pwm_out      registered PWM outputs, one per channel
//   period_start 1-cycle pulse in the cycle pwm_out first shows cnt = 0
module pwm_dac_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);

  localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_shadow [CHANNELS];
  logic [WIDTH-1:0] r_active [CHANNELS];
  logic             r_mode_active;
  // Marks the first clock of a period (after a boundary, en low or reset).
  logic             r_first;
  logic [CHANNELS-1:0] r_pwm;
  logic             r_pstart;

  logic             w_tick;
  logic [WIDTH:0]   w_p_inc;
  logic [WIDTH-1:0] w_cnt;
  logic             w_boundary;
  logic             w_apply;
  logic [WIDTH-1:0] w_shadow_nxt [CHANNELS];

  // Tick, count value and boundary detection.
  always_comb begin
    w_tick  = (r_presc == PRESC_LAST);
    w_p_inc = r_p + (WIDTH+1)'(1);
    // Centre mode folds the upper half of the phase back down.
    if (r_mode_active && r_p[WIDTH]) begin
      w_cnt = ~r_p[WIDTH-1:0];
    end else begin
      w_cnt = r_p[WIDTH-1:0];
    end
    if (r_mode_active) begin
      w_boundary = en & w_tick & (w_p_inc == {(WIDTH+1){1'b0}});
    end else begin
      w_boundary = en & w_tick & (w_p_inc[WIDTH-1:0] == {WIDTH{1'b0}});
    end
    // While disabled the active set tracks shadow/mode continuously.
    w_apply = ~en | w_boundary;
  end

  // Next shadow values; a load on a boundary edge reaches active directly
  // because active copies this next value rather than the old shadow.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (load) begin
        w_shadow_nxt[i] = duty_in[i*WIDTH +: WIDTH];
      end else begin
        w_shadow_nxt[i] = r_shadow[i];
      end
    end
  end

  // Counter, duty registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_p           <= '0;
      r_mode_active <= 1'b0;
      r_first       <= 1'b1;
      r_pwm         <= '0;
      r_pstart      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_pstart <= en & r_first;
      r_first  <= ~en | w_boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        r_pwm[i]    <= en & (w_cnt < r_active[i]);
        r_shadow[i] <= w_shadow_nxt[i];
        if (w_apply) begin
          r_active[i] <= w_shadow_nxt[i];
        end
      end
      if (w_apply) begin
        r_mode_active <= mode;
      end
      if (!en) begin
        r_presc <= '0;
        r_p     <= '0;
      end else begin
        if (w_tick) begin
          r_presc <= '0;
          r_p     <= w_p_inc;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_pstart;

endmodule

// File: doc/pwm_dac_multi.md
Name: pwm_dac_multi

Overview:
Multi-channel, parametrised PWM DAC. It drives CHANNELS pulse-width outputs from a shared period counter, and an external RC filter turns each output into an analog level. Per-channel duty words pass through shadow registers and are applied only at period boundaries, so updates cause no glitches. It supports edge-aligned and centre-aligned modes and a clock prescaler. It sits between the control/datapath logic and the board DAC pins.

Parameters:
WIDTH, 8, duty and counter resolution in bits (MAX = 2^WIDTH-1)
CHANNELS, 4, number of independent PWM outputs
DIV, 1, prescaler; counter advances once every DIV clk cycles (DIV >= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  run enable
mode  in  1  0 = edge-aligned, 1 = centre-aligned
load  in  1  1-cycle strobe; captures duty_in into shadow registers
duty_in  in  CHANNELS*WIDTH  channel i duty at bits [i*WIDTH +: WIDTH]
pwm_out  out  CHANNELS  registered PWM outputs
period_start  out  1  1-cycle pulse marking the first clock of each period

Behaviour:
- Reset (rst_n=0 at a clk edge): prescaler=0, phase p=0, shadow duties=0, active duties=0, mode_active=0, pwm_out=0, period_start=0.
- Prescaler: tick=1 when the prescaler equals DIV-1, then the prescaler wraps to 0. With DIV=1, tick=1 on every clk.
- Phase counter p is WIDTH+1 bits and advances by 1 on each tick while en=1. It wraps naturally.
- Edge mode: cnt = p[WIDTH-1:0]; period = 2^WIDTH ticks. p[WIDTH] is ignored; a boundary occurs whenever p[WIDTH-1:0] wraps to 0.
- Centre mode: cnt = p[WIDTH] ? ~p[WIDTH-1:0] : p[WIDTH-1:0]. The count runs 0..MAX then MAX..0, each value twice. Period = 2^(WIDTH+1) ticks; a boundary occurs when the full p wraps to 0.
- Output: on every clk, pwm_out[i] <= en & (cnt < duty_active[i]). This gives 1 clk of latency from the counter value.
  - duty=0 gives a constant 0.
  - Edge mode: duty=MAX gives high for MAX of 2^WIDTH ticks.
  - Centre mode: high for 2*duty ticks, centred on the period boundary.
- Boundary edge (the tick edge at which p/cnt becomes 0): active duties <= shadow and mode_active <= mode. The new duty governs the same period.
- period_start is registered and is 1 for exactly the clk cycle in which pwm_out first reflects cnt=0 of a new period.
- load: shadow <= duty_in on the edge where load=1.
  - If load coincides with a boundary edge, duty_in bypasses the shadow and goes straight to active for that period.
  - Back-to-back loads within one period: the last one wins.
- mode is used only through mode_active. A mode change mid-period takes effect at the next boundary, and p is not altered by the change.
- en=0: p=0, prescaler=0, pwm_out=0, period_start=0. Active duties and mode_active track shadow/mode continuously, and loads are still accepted.
- en 0→1: the counter restarts at cnt=0 with the current shadow values. The first clk with en=1 counts as period start, so period_start pulses on the next clk.
- rst_n low mid-period: full reset values on that edge, no partial period. Restart behaves as for en rising.

Test Plan:
1. WIDTH=8, DIV=1, edge mode, en=1, load duties {0,1,128,255} → over any 256-clk period, pwm_out high counts are 0, 1, 128, 255. Each high run starts in the cycle period_start=1; period_start pulses every 256 clks.
2. Centre mode, duty ch0=64 → over a 512-clk period, ch0 is high for 128 clks as one contiguous run straddling the boundary (64 before, 64 after period_start). Duty 0 → constant 0.
3. Edge mode, duty 10 running; load 200 at cnt=50 → that period still shows 10 high clks; the next period, starting at period_start, shows 200.
4. load 77 on the exact boundary edge → 77 high clks in that period. load 5 then load 9 in one period → 9 applied at the next boundary.
5. DIV=4, duty 128 → period_start every 1024 clks; 512 high clks per period, changing only on tick edges.
6. rst_n=0 for 1 clk mid-period → all outputs 0 and duties 0 the next cycle. en=0 for 20 clks → pwm_out=0 and period_start=0; after en=1, period_start pulses on the following clk.
